// File: rtl/calculator_ctrl.sv
// calculator_ctrl: debounces the user button, captures operands on an accepted press,
// drives one ALU operation with timeout and latches the result for the display.
module calculator_ctrl #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [2:0]  func,
    input  logic [7:0]  num1,
    input  logic [7:0]  num2,
    output logic        alu_start,
    output logic [2:0]  alu_func,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    input  logic        alu_error,
    output logic [31:0] cal_result,
    output logic        flag_error,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);
    localparam logic [CNT_W-1:0] DEB      = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    typedef enum logic [2:0] {IDLE, PRESS, ISSUE, WAIT, RELEASE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0] sync;
    logic btn_s, illegal, accept, done_hit, tmo_hit;
    assign btn_s     = sync[1];
    assign illegal   = func == 3'b111;
    assign alu_start = state == ISSUE;
    assign busy      = state == ISSUE || state == WAIT;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b00;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], button};
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // One counter serves press debounce, ALU timeout and release debounce.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        accept   = 1'b0;
        done_hit = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            IDLE: begin
                state_n = btn_s ? PRESS : IDLE;
                cnt_n   = btn_s ? ONE : '0;
            end
            PRESS: begin
                accept  = btn_s && cnt == DEB;
                state_n = !btn_s ? IDLE : accept ? (illegal ? RELEASE : ISSUE) : PRESS;
                cnt_n   = (!btn_s || accept) ? '0 : cnt + ONE;
            end
            ISSUE: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                done_hit = alu_done;
                tmo_hit  = !alu_done && cnt == TMO_LAST;
                state_n  = (done_hit || tmo_hit) ? RELEASE : WAIT;
                cnt_n    = (done_hit || tmo_hit) ? '0 : cnt + ONE;
            end
            RELEASE: begin
                state_n = (!btn_s && cnt == DEB_LAST) ? IDLE : RELEASE;
                cnt_n   = (btn_s || cnt == DEB_LAST) ? '0 : cnt + ONE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_func     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            cal_result   <= '0;
            flag_error   <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= accept && illegal || done_hit || tmo_hit;
            if (accept) begin
                alu_func    <= func;
                alu_a       <= num1;
                alu_b       <= num2;
                timeout_err <= 1'b0;
            end
            if (accept && illegal) begin
                cal_result <= '0;
                flag_error <= 1'b1;
            end
            if (done_hit) begin
                cal_result <= alu_result;
                flag_error <= alu_error;
            end
            // A timeout keeps the previous result on the display.
            if (tmo_hit) begin
                flag_error  <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_calculator_ctrl.sv
// tb_calculator_ctrl: directed and random button/ALU scenarios checked against
// an operation-level model of the controller and a behavioural ALU.
module tb_calculator_ctrl;
    logic clk, rst, button, alu_done, alu_error, alu_start, busy;
    logic flag_error, result_valid, timeout_err;
    logic [2:0] func, alu_func;
    logic [7:0] num1, num2, alu_a, alu_b;
    logic [31:0] alu_result, cal_result, model_cal;
    int tests, fails, cyc, n_start, n_rv, start_cyc, rise_cyc, timer, alu_lat, inject_at;
    int s0, r0;
    logic [2:0] rf;
    logic [7:0] ra, rb;

    calculator_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .button(button), .func(func), .num1(num1), .num2(num2),
        .alu_start(alu_start), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
        .cal_result(cal_result), .flag_error(flag_error), .result_valid(result_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {error, result} of the external ALU
    function automatic logic [32:0] alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'd0: return {1'b0, 32'(a) + 32'(b)};
            3'd1: return {1'b0, 32'(a) - 32'(b)};
            3'd2: return {1'b0, 32'(a) * 32'(b)};
            3'd3: return (b == 8'd0) ? {1'b1, 32'h0} : {1'b0, 32'(a / b)};
            default: return {1'b0, 32'(a ^ b)};
        endcase
    endfunction

    // Environment: cycle counter, pulse monitors and an ALU answering after alu_lat cycles.
    initial begin
        alu_done = 1'b0;
        alu_result = '0;
        alu_error = 1'b0;
        cyc = 0;
        n_start = 0;
        n_rv = 0;
        start_cyc = 0;
        timer = -1;
        rf = '0;
        ra = '0;
        rb = '0;
        forever begin
            @(negedge clk);
            cyc++;
            alu_done = 1'b0;
            if (alu_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (result_valid) n_rv++;
            if (timer > 0) timer--;
            if (timer == 0) begin
                {alu_error, alu_result} = alu_ref(rf, ra, rb);
                alu_done = 1'b1;
                timer = -1;
            end
            if (alu_start && alu_lat > 0) begin
                timer = alu_lat;
                rf = alu_func;
                ra = alu_a;
                rb = alu_b;
            end
            if (cyc == inject_at) begin
                alu_done = 1'b1;
                alu_result = 32'h55;
                alu_error = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One press-to-result operation; lat==0 means the ALU never answers.
    task automatic do_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input int lat, input bit rebounce);
        int s, r;
        bit legal;
        logic [32:0] res;
        logic [31:0] ecal;
        logic eflag, eto;
        s = n_start;
        r = n_rv;
        legal = f != 3'b111;
        res = alu_ref(f, a, b);
        ecal = !legal ? 32'h0 : (lat == 0 ? model_cal : res[31:0]);
        eflag = !legal || lat == 0 || res[32];
        eto = legal && lat == 0;
        alu_lat = lat;
        func = f;
        num1 = a;
        num2 = b;
        button = 1'b1;
        rise_cyc = cyc;
        repeat (hold) tick();
        button = 1'b0;
        for (int i = 0; i < 80 && n_rv == r; i++) tick();
        if (rebounce) begin
            tick();
            tick();
            button = 1'b1;
            repeat (10) tick();
            button = 1'b0;
        end
        repeat (10) tick();
        check("start_count", 64'(n_start - s), 64'(legal));
        check("valid_count", 64'(n_rv - r), 64'd1);
        if (legal) check("start_latency", 64'(start_cyc - rise_cyc), 64'd7);
        check("cal_result", 64'(cal_result), 64'(ecal));
        check("flag_error", 64'(flag_error), 64'(eflag));
        check("timeout_err", 64'(timeout_err), 64'(eto));
        check("busy_idle", 64'(busy), 64'd0);
        check("captured", 64'({alu_func, alu_a, alu_b}), 64'({f, a, b}));
        model_cal = ecal;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        alu_lat = 0;
        inject_at = -1;
        model_cal = '0;
        rst = 1'b0;
        button = 1'b0;
        func = '0;
        num1 = '0;
        num2 = '0;
        #1;
        check("reset_outputs", 64'({alu_start, busy, result_valid, flag_error, timeout_err,
              alu_func, alu_a, alu_b, cal_result}), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // clean press
        do_op(3'b000, 8'h12, 8'h34, 10, 3, 1'b0);

        // bounce never accepted
        s0 = n_start;
        r0 = n_rv;
        for (int k = 0; k < 3; k++) begin
            button = 1'b1;
            tick();
            tick();
            button = 1'b0;
            tick();
        end
        repeat (12) tick();
        check("bounce_start", 64'(n_start - s0), 64'd0);
        check("bounce_valid", 64'(n_rv - r0), 64'd0);
        check("bounce_cal", 64'(cal_result), 64'(model_cal));
        check("bounce_busy", 64'(busy), 64'd0);

        // illegal function
        do_op(3'b111, 8'hA5, 8'h5A, 10, 3, 1'b0);

        // timeout keeps previous result
        do_op(3'b001, 8'h50, 8'h20, 10, 2, 1'b0);
        s0 = n_start;
        r0 = n_rv;
        alu_lat = 0;
        func = 3'b010;
        num1 = 8'h09;
        num2 = 8'h03;
        button = 1'b1;
        for (int i = 0; i < 40 && n_start == s0; i++) tick();
        check("to_start", 64'(n_start - s0), 64'd1);
        while (cyc < start_cyc + 8) tick();
        check("to_busy_last", 64'(busy), 64'd1);
        check("to_err_early", 64'(timeout_err), 64'd0);
        tick();
        check("to_busy_fall", 64'(busy), 64'd0);
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_flag", 64'(flag_error), 64'd1);
        check("to_cal", 64'(cal_result), 64'(model_cal));
        check("to_valid", 64'({result_valid, 32'(n_rv - r0)}), {32'd1, 32'd1});
        button = 1'b0;
        repeat (10) tick();
        do_op(3'b000, 8'h01, 8'h02, 8, 2, 1'b0);

        // held button with divide by zero, then re-press inside release debounce
        do_op(3'b011, 8'h77, 8'h00, 40, 3, 1'b0);
        do_op(3'b000, 8'h05, 8'h06, 20, 2, 1'b1);
        do_op(3'b001, 8'h10, 8'h03, 10, 2, 1'b0);

        // random operations
        for (int k = 0; k < 16; k++) begin
            logic [2:0] f;
            logic [7:0] a, b;
            int lat;
            f = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            do_op(f, a, b, int'($urandom_range(8, 24)), lat, 1'b0);
        end

        // reset in the middle of WAIT, late done ignored
        s0 = n_start;
        r0 = n_rv;
        alu_lat = 0;
        func = 3'b000;
        num1 = 8'h03;
        num2 = 8'h04;
        button = 1'b1;
        for (int i = 0; i < 40 && n_start == s0; i++) tick();
        check("rst_start", 64'(n_start - s0), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        button = 1'b0;
        #1;
        check("rst_outputs", 64'({alu_start, busy, result_valid, flag_error, timeout_err,
              alu_func, alu_a, alu_b, cal_result}), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        inject_at = cyc + 1;
        repeat (6) tick();
        check("rst_no_valid", 64'(n_rv - r0), 64'd0);
        check("rst_no_restart", 64'(n_start - s0), 64'd1);
        check("rst_idle", 64'({busy, flag_error, cal_result}), 64'd0);
        model_cal = '0;
        do_op(3'b010, 8'h0C, 8'h0B, 10, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/calculator_ctrl.md
Name: calculator_ctrl

Overview:
- Sequences the calculator datapath from the user button.
- Synchronises and debounces `button`, then captures `func`/`num1`/`num2` on an accepted press.
- Issues a one-cycle start to a multi-cycle ALU and waits for done, with a timeout.
- Latches the result and error flag for the display. Sits between the board inputs and the ALU/display in the top level, clocked by clk_g.

Parameters:
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles of synced button needed to accept a press or a release; minimum 2.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before the operation is aborted; minimum 2.
- CNT_W, 20, width of the shared debounce/timeout counter; must hold the larger of the two parameters.

Ports:
- clk  in  1  system clock (clk_g).
- rst  in  1  asynchronous, active-low reset.
- button  in  1  raw push button, asynchronous.
- func  in  3  operation select; 3'b111 is illegal.
- num1  in  8  operand A.
- num2  in  8  operand B.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_func  out  3  captured func, held stable from alu_start until done.
- alu_a  out  8  captured num1, held stable from alu_start until done.
- alu_b  out  8  captured num2, held stable from alu_start until done.
- alu_done  in  1  ALU completion pulse; alu_result and alu_error are valid in the same cycle.
- alu_result  in  32  ALU result.
- alu_error  in  1  ALU error, e.g. divide by zero.
- cal_result  out  32  latched result to the display.
- flag_error  out  1  latched error to the display.
- result_valid  out  1  one-cycle pulse when cal_result/flag_error update.
- busy  out  1  high while in ISSUE or WAIT.
- timeout_err  out  1  sticky; set on ALU timeout, cleared by the next accepted press.

Behaviour:
- Reset (rst=0, async) values:
  - All outputs 0, including cal_result = 32'h0.
  - Both synchroniser flops 0; state IDLE.
- Synchroniser: two flops on button, giving btn_s. btn_s lags raw button by 2 clk edges.
- States: IDLE, PRESS, ISSUE, WAIT, RELEASE.
- IDLE:
  - Counter holds 0 while btn_s=0.
  - On btn_s=1, go to PRESS with counter = 1.
- PRESS:
  - btn_s=1: counter increments. When it reaches DEBOUNCE_CYCLES the press is accepted.
  - btn_s=0 before that: return to IDLE, counter 0, no capture.
  - On acceptance: capture func/num1/num2 into alu_func/alu_a/alu_b and clear timeout_err.
  - If func==3'b111: set flag_error=1, cal_result=0, pulse result_valid next cycle, go to RELEASE. No alu_start.
  - Otherwise go to ISSUE.
- ISSUE:
  - Exactly one cycle: alu_start=1, busy=1, then go to WAIT with counter = 0.
  - alu_start is high exactly one cycle after the acceptance cycle.
- WAIT:
  - busy=1; counter increments each cycle.
  - On alu_done=1: cal_result<=alu_result, flag_error<=alu_error, result_valid pulses the following cycle, go to RELEASE.
  - If alu_done arrives on the same cycle the counter reaches TIMEOUT_CYCLES, done wins.
  - On counter reaching TIMEOUT_CYCLES with no done: timeout_err=1, flag_error=1, cal_result unchanged, result_valid pulse, go to RELEASE.
- RELEASE:
  - Counts consecutive btn_s=0 cycles; any btn_s=1 resets the count to 0.
  - At DEBOUNCE_CYCLES, return to IDLE.
  - Guarantees one operation per physical press.
- Button activity in ISSUE/WAIT is ignored. A press held through WAIT is absorbed by RELEASE, with no retrigger.
- alu_done outside WAIT is ignored.
- cal_result and flag_error hold their values between operations. They change only on the result_valid update.
- alu_func/alu_a/alu_b change only on acceptance. Input changes at other times have no effect.
- Async reset asserted mid-WAIT: immediate return to reset values; a late alu_done after reset release is ignored (IDLE).

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8):
1. Clean press: func=3'b000, num1=8'h12, num2=8'h34, button held high 10 cycles. ALU model returns done 3 cycles after start with result 32'h46, error 0.
   - alu_start exactly once, 2+4+1 cycles after the raw rise.
   - alu_a=8'h12, alu_b=8'h34.
   - cal_result=32'h46, flag_error=0, one result_valid pulse.
2. Bounce: button toggles high 2 cycles, low 1 cycle, 3 times, then low.
   - No alu_start; cal_result unchanged; state returns to IDLE.
3. Illegal func=3'b111, clean press.
   - No alu_start; flag_error=1; cal_result=0; one result_valid.
4. Timeout: ALU model never asserts done.
   - After 8 WAIT cycles: timeout_err=1, flag_error=1, busy falls, previous cal_result retained.
   - Next valid press clears timeout_err.
5. Held button plus divide by zero: button held 40 cycles; ALU returns alu_error=1 with result 0.
   - Exactly one alu_start; flag_error=1.
   - Second alu_start only after release ≥4 cycles and a new press.
6. Reset mid-WAIT: drop rst 2 cycles after alu_start, then done pulses 1 cycle after rst rises.
   - All outputs 0 immediately; late done ignored; no result_valid.
